// File: rtl/shift_reg_pkg.sv
// shift_reg_pkg: shared state encoding and direction constants for the shift register unit
package shift_reg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_ctrl.sv
// shift_ctrl: command FSM, saturating shift down-counter and latched shift mode
module shift_ctrl
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             start,
    input  logic [CNT_W-1:0] amount,
    input  logic             dir,
    input  logic             rotate,
    output logic             load_en,
    output logic             shift_en,
    output logic             dir_q,
    output logic             rotate_q,
    output logic             busy,
    output logic             done
);

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] amt_sat;

    assign amt_sat  = (amount > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : amount;
    assign load_en  = (state == ST_IDLE) && load;
    assign shift_en = (state == ST_SHIFT);

    // Sequence IDLE -> SHIFT -> DONE; Load has priority over Start, commands outside IDLE are dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            count    <= '0;
            dir_q    <= 1'b0;
            rotate_q <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!load && start) begin
                        dir_q    <= dir;
                        rotate_q <= rotate;
                        count    <= amt_sat;
                        if (amt_sat == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_SHIFT;
                            busy  <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    count <= count - CNT_W'(1);
                    if (count == CNT_W'(1)) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/shift_reg_unit.sv
// shift_reg_unit: universal shift register with parallel load and multi-cycle shift/rotate by N
module shift_reg_unit
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Load,
    input  logic [WIDTH-1:0] D,
    input  logic             Start,
    input  logic [CNT_W-1:0] Amount,
    input  logic             Dir,
    input  logic             Rotate,
    input  logic             SerIn,
    output logic [WIDTH-1:0] Q,
    output logic             SerOut,
    output logic             Busy,
    output logic             Done
);

    logic             load_en;
    logic             shift_en;
    logic             dir_q;
    logic             rotate_q;
    logic             out_bit;
    logic             fill;
    logic [WIDTH-1:0] q_next;

    shift_ctrl #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) u_ctrl (
        .clk     (Clk),
        .rst     (Reset),
        .load    (Load),
        .start   (Start),
        .amount  (Amount),
        .dir     (Dir),
        .rotate  (Rotate),
        .load_en (load_en),
        .shift_en(shift_en),
        .dir_q   (dir_q),
        .rotate_q(rotate_q),
        .busy    (Busy),
        .done    (Done)
    );

    // Single-bit shift step: pick the outgoing bit and the fill bit for the latched direction and mode
    always_comb begin
        out_bit = (dir_q == DIR_RIGHT) ? Q[0] : Q[WIDTH-1];
        fill    = rotate_q ? out_bit : SerIn;
        q_next  = (dir_q == DIR_RIGHT) ? {fill, Q[WIDTH-1:1]} : {Q[WIDTH-2:0], fill};
    end

    // Storage: load or shift only when commanded, otherwise hold
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Q      <= '0;
            SerOut <= 1'b0;
        end else if (load_en) begin
            Q <= D;
        end else if (shift_en) begin
            Q      <= q_next;
            SerOut <= out_bit;
        end
    end

endmodule

// File: doc/shift_reg_unit.md
# shift_reg_unit

Parametrised universal shift register with a command FSM. It holds a WIDTH-bit word built from edge-triggered storage, and supports parallel load, multi-cycle shift-by-N (left or right, logical with serial fill or rotate), with Busy/Done handshake. It sits between the board switch/LED wrapper and downstream datapath labs as the general storage/serialiser element.

## Interface
Parameters:
- WIDTH, 8, word width in bits (≥2)
- CNT_W, $clog2(WIDTH)+1, width of Amount and internal shift counter (derived; not overridden)

Ports:
- Clk  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high reset
- Load  in  1  parallel-load request, sampled in IDLE only
- D  in  WIDTH  parallel load data
- Start  in  1  shift command request, sampled in IDLE only
- Amount  in  CNT_W  number of single-bit shifts, sampled with Start
- Dir  in  1  0 = left (toward MSB), 1 = right; sampled with Start
- Rotate  in  1  1 = rotate, 0 = logical shift with SerIn fill; sampled with Start
- SerIn  in  1  fill bit, sampled live on every shift edge
- Q  out  WIDTH  register contents
- SerOut  out  1  last bit shifted/rotated out
- Busy  out  1  high in SHIFT state
- Done  out  1  one-cycle pulse, high in DONE state

## Operation
- States: IDLE, SHIFT, DONE. Busy = (state==SHIFT); Done = (state==DONE).
- IDLE: Load=1 → Q<=D, stay IDLE. Else Start=1 → latch Dir, Rotate; count<=min(Amount, WIDTH); count==0 → DONE, else → SHIFT.
- Load and Start together in IDLE: Load wins, Start dropped.
- SHIFT: each edge performs one shift, count<=count-1; when count==1 at the edge → DONE.
- Left: Q<={Q[WIDTH-2:0], fill}, SerOut<=Q[WIDTH-1]. Right: Q<={fill, Q[WIDTH-1:1]}, SerOut<=Q[0]. fill = Rotate ? outgoing bit : SerIn.
- DONE: lasts exactly one cycle, then IDLE. Load/Start in DONE ignored.
- Load/Start while SHIFT ignored; no queuing.
- Amount > WIDTH saturates to WIDTH.
- Reset (any time, including mid-shift): Q=0, SerOut=0, Busy=0, Done=0, state IDLE, count=0, latched Dir/Rotate=0, immediately, without waiting for Clk.

## Timing
- Load at edge k → Q=D after edge k.
- Start (Amount=N, 1≤N≤WIDTH) at edge k → Busy high after k; shifts at edges k+1..k+N; Busy low and Done high after edge k+N; Done low after edge k+N+1; next Start accepted at edge k+N+2.
- Amount=0 at edge k → Done high after edge k, Q unchanged, Busy never asserted.
- Q and SerOut update only on edges that perform a shift or load; otherwise hold.
- No combinational path from inputs to outputs.

## Structure
- Shared package shift_reg_pkg: state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2), DIR_LEFT/DIR_RIGHT constants.
- One sub-module: shift_ctrl (FSM + down counter + Dir/Rotate latches, outputs shift_en, Busy, Done). Datapath (Q, SerOut, fill mux) lives in shift_reg_unit.

## Test plan
WIDTH=8 throughout.
- Reset, then Load D=8'hA5 → Q=8'hA5 after one edge, Busy=0, Done=0.
- From 8'hA5: Start, Amount=3, Dir=0, Rotate=0, SerIn=1 → Busy 3 cycles, Q=8'h2F, SerOut=1, single Done pulse.
- From 8'hA5: Start, Amount=4, Dir=1, Rotate=1 → Q=8'h5A after 4 shifts, SerOut=0; Amount=0 → Done next cycle, Q unchanged, Busy never high.
- From 8'hFF: Amount=12, Dir=0, SerIn=0 → exactly 8 shifts (saturation), Q=8'h00, Done after 8th shift.
- During shift: Start and Load pulsed while Busy → ignored, Q follows shift sequence only; Load+Start same cycle in IDLE → load only, no Busy.
- Assert Reset between edges after 2 shifts → Q=0, Busy=0, Done=0, SerOut=0 before next Clk edge; after release, new Load/Start accepted normally.
